// File: rtl/iroh_mem_responder_if.sv
// rtl/iroh_mem_responder_if.sv - CPU memory bus and program-loader signals of the Iroh memory responder
interface iroh_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic                  enable;
    logic                  wEnable;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     newWord;
    logic [DATA_W-1:0]     wordOut;
    logic                  ld_start;
    logic                  ld_valid;
    logic [DATA_W/2-1:0]   ld_byte;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  cpu_hold;
    logic                  ld_done;
    logic                  ld_wrap;

    modport master (
        output enable, wEnable, addr, newWord, ld_start, ld_valid, ld_byte, ld_last,
        input  wordOut, ld_ready, cpu_hold, ld_done, ld_wrap
    );

    modport slave (
        input  enable, wEnable, addr, newWord, ld_start, ld_valid, ld_byte, ld_last,
        output wordOut, ld_ready, cpu_hold, ld_done, ld_wrap
    );
endinterface

// File: rtl/iroh_mem_responder.sv
// rtl/iroh_mem_responder.sv - single-port RAM serving CPU reads/writes plus a byte-stream program loader
module iroh_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    iroh_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int B_W   = DATA_W / 2;

    typedef enum logic [1:0] {RUN, LOAD_HI, LOAD_LO, COMMIT} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ptr;
    logic [B_W-1:0]      hi, lo;
    logic                last_f;
    logic [DATA_W-1:0]   word_q;
    logic                wrap_q;

    logic                ld_ready, cpu_hold, ld_done, ld_hs;
    logic                cpu_wr, cpu_rd;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.ld_start) state_next = LOAD_HI;
            LOAD_HI: if (ld_hs) state_next = bus.ld_last ? COMMIT : LOAD_LO;
            LOAD_LO: if (ld_hs) state_next = COMMIT;
            COMMIT:  state_next = last_f ? RUN : LOAD_HI;
            default: state_next = RUN;
        endcase
    end

    // The single RAM port is owned by the CPU in RUN and by the loader in COMMIT.
    always_comb begin
        ld_ready  = (state == LOAD_HI) || (state == LOAD_LO);
        cpu_hold  = (state != RUN);
        ld_done   = (state == COMMIT) && last_f;
        ld_hs     = bus.ld_valid && ld_ready;
        cpu_wr    = (state == RUN) && bus.enable && bus.wEnable;
        cpu_rd    = (state == RUN) && bus.enable && !bus.wEnable;
        mem_we    = cpu_wr || (state == COMMIT);
        mem_addr  = (state == COMMIT) ? ptr : bus.addr;
        mem_wdata = (state == COMMIT) ? {hi, lo} : bus.newWord;
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            ptr    <= '0;
            hi     <= '0;
            lo     <= '0;
            last_f <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            if (cpu_wr)      word_q <= bus.newWord;
            else if (cpu_rd) word_q <= mem[bus.addr];
            case (state)
                RUN: begin
                    if (bus.ld_start) begin
                        ptr    <= '0;
                        wrap_q <= 1'b0;
                    end
                end
                LOAD_HI: begin
                    if (ld_hs) begin
                        hi <= bus.ld_byte;
                        if (bus.ld_last) begin
                            lo     <= '0;
                            last_f <= 1'b1;
                        end
                    end
                end
                LOAD_LO: begin
                    if (ld_hs) begin
                        lo     <= bus.ld_byte;
                        last_f <= bus.ld_last;
                    end
                end
                COMMIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) wrap_q <= 1'b1;
                    if (last_f) last_f <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.wordOut  = word_q;
    assign bus.ld_ready = ld_ready;
    assign bus.cpu_hold = cpu_hold;
    assign bus.ld_done  = ld_done;
    assign bus.ld_wrap  = wrap_q;
endmodule

// File: tb/tb_iroh_mem_responder.sv
// tb/tb_iroh_mem_responder.sv - directed vector bench for iroh_mem_responder
module tb_iroh_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    iroh_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    iroh_mem_responder #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        we;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t       vecs [10];
    int         checks = 0;
    int         errors = 0;
    bit         mon = 0;
    int         hold_cnt, nr_cnt, done_cnt;
    bit         tmo;
    logic [7:0] bq [$];
    int         gq [$];

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon) begin
            if (bus.cpu_hold) hold_cnt++;
            if (bus.cpu_hold && !bus.ld_ready) nr_cnt++;
            if (bus.ld_done) done_cnt++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [15:0] e, input string nm);
        bus.enable  = 1'b1;
        bus.wEnable = 1'b0;
        bus.addr    = a;
        tick();
        bus.enable  = 1'b0;
        chk(nm, bus.wordOut, e);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.ld_ready && k < 20) begin
            tick();
            k++;
        end
        if (!bus.ld_ready) tmo = 1'b1;
    endtask

    task automatic feed_byte(input logic [7:0] b, input logic last);
        bus.ld_byte  = b;
        bus.ld_last  = last;
        bus.ld_valid = 1'b1;
        wait_ready();
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic wait_run();
        int k = 0;
        while (bus.cpu_hold && k < 20) begin
            tick();
            k++;
        end
        if (bus.cpu_hold) tmo = 1'b1;
    endtask

    task automatic do_load(input string nm, input int nwords, input int gap_sum);
        hold_cnt = 0; nr_cnt = 0; done_cnt = 0; tmo = 1'b0;
        mon = 1;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < bq.size(); i++) begin
            if (gq[i] > 0) begin
                bus.ld_valid = 1'b0;
                wait_ready();
                repeat (gq[i]) tick();
            end
            bus.ld_byte  = bq[i];
            bus.ld_last  = (i == bq.size() - 1);
            bus.ld_valid = 1'b1;
            wait_ready();
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        wait_run();
        mon = 0;
        chk({nm, " timeout"}, 32'(tmo), 32'd0);
        chk({nm, " hold_cycles"}, hold_cnt, bq.size() + nwords + gap_sum);
        chk({nm, " done_pulses"}, done_cnt, 32'd1);
        chk({nm, " commit_not_ready"}, nr_cnt, nwords);
    endtask

    initial begin
        bus.enable = 0; bus.wEnable = 0; bus.addr = 0; bus.newWord = 0;
        bus.ld_start = 0; bus.ld_valid = 0; bus.ld_byte = 0; bus.ld_last = 0;

        vecs[0] = '{1, 1, 8'h10, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1, 0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[2] = '{0, 0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[3] = '{0, 1, 8'h20, 16'h5555, 16'hBEEF};
        vecs[4] = '{0, 0, 8'h00, 16'h0000, 16'hBEEF};
        vecs[5] = '{1, 1, 8'h20, 16'h1234, 16'h1234};
        vecs[6] = '{1, 0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[7] = '{1, 0, 8'h20, 16'hFFFF, 16'h1234};
        vecs[8] = '{0, 1, 8'h10, 16'h0000, 16'h1234};
        vecs[9] = '{1, 0, 8'h10, 16'h0000, 16'hBEEF};

        tick(); tick();
        rst = 1'b0;
        chk("reset wordOut", bus.wordOut, 16'h0);
        chk("reset ld_ready", bus.ld_ready, 1'b0);
        chk("reset cpu_hold", bus.cpu_hold, 1'b0);
        chk("reset ld_done", bus.ld_done, 1'b0);
        chk("reset ld_wrap", bus.ld_wrap, 1'b0);

        for (int i = 0; i < 10; i++) begin
            bus.enable  = vecs[i].en;
            bus.wEnable = vecs[i].we;
            bus.addr    = vecs[i].a;
            bus.newWord = vecs[i].d;
            tick();
            chk($sformatf("vec%0d wordOut", i), bus.wordOut, vecs[i].exp);
        end
        bus.enable = 0; bus.wEnable = 0;

        bq = '{8'h12, 8'h34, 8'h56, 8'h78}; gq = '{0, 0, 0, 0};
        do_load("load4", 2, 0);
        chk("load4 wrap", bus.ld_wrap, 1'b0);
        cpu_read(8'h01, 16'h5678, "load4 mem1");
        cpu_read(8'h00, 16'h1234, "load4 mem0");

        bq = '{8'hAB, 8'hCD, 8'hEF}; gq = '{0, 0, 0};
        do_load("odd", 2, 0);
        cpu_read(8'h00, 16'hABCD, "odd mem0");
        cpu_read(8'h01, 16'hEF00, "odd mem1");

        bq = '{8'h12, 8'h34, 8'h56, 8'h78}; gq = '{1, 2, 0, 3};
        do_load("gaps", 2, 6);
        cpu_read(8'h00, 16'h1234, "gaps mem0");
        cpu_read(8'h01, 16'h5678, "gaps mem1");

        tmo = 1'b0;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        feed_byte(8'h11, 1'b0);
        bus.enable = 1'b1; bus.wEnable = 1'b1; bus.addr = 8'h00; bus.newWord = 16'hFFFF;
        tick(); tick();
        chk("lo_write wordOut hold", bus.wordOut, 16'h5678);
        chk("lo_write cpu_hold", bus.cpu_hold, 1'b1);
        bus.enable = 1'b0; bus.wEnable = 1'b0;
        feed_byte(8'h22, 1'b1);
        wait_run();
        chk("lo_write timeout", 32'(tmo), 32'd0);
        cpu_read(8'h00, 16'h1122, "lo_write mem0");

        bq.delete(); gq.delete();
        for (int k = 0; k < 257; k++) begin
            bq.push_back(8'hC0 + 8'(k >> 8));
            bq.push_back(8'(k));
            gq.push_back(0);
            gq.push_back(0);
        end
        do_load("wrap", 257, 0);
        chk("wrap ld_wrap", bus.ld_wrap, 1'b1);
        cpu_read(8'h00, 16'hC100, "wrap mem0");
        cpu_read(8'h01, 16'hC001, "wrap mem1");
        cpu_read(8'hFF, 16'hC0FF, "wrap mem255");

        tmo = 1'b0;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        feed_byte(8'hA1, 1'b0);
        feed_byte(8'hA2, 1'b0);
        feed_byte(8'hB1, 1'b0);
        feed_byte(8'hB2, 1'b0);
        feed_byte(8'hC1, 1'b0);
        chk("abort in LOAD_LO", {bus.cpu_hold, bus.ld_ready}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort timeout", 32'(tmo), 32'd0);
        chk("abort wordOut", bus.wordOut, 16'h0);
        chk("abort ld_ready", bus.ld_ready, 1'b0);
        chk("abort cpu_hold", bus.cpu_hold, 1'b0);
        chk("abort ld_done", bus.ld_done, 1'b0);
        chk("abort ld_wrap", bus.ld_wrap, 1'b0);
        cpu_read(8'h00, 16'hA1A2, "abort mem0");
        cpu_read(8'h01, 16'hB1B2, "abort mem1");
        cpu_read(8'h02, 16'hC002, "abort mem2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
